rat_int_ctrl: RTL and testbench

//  Interrupt controller for the RAT MCU. Latches rising edges from up to N_SRC

---
 rtl/rat_int_ctrl.sv | 152 +++++++++++++++
 tb/tb_rat_int_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rat_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rat_int_ctrl
// Description : Interrupt controller for the RAT MCU. Latches rising edges
//               from one-shot sources, applies a CPU-written enable mask, and
//               dispatches the lowest-index enabled pending source as a timed
//               pulse on the CPU INTERRUPT input. The ISR reads status and
//               pending vectors and acknowledges through the PORT_ID/IO_STRB
//               bus.
// Revision    : 1.0 - initial release
// ============================================================================
module rat_int_ctrl #(
  parameter int         N_SRC      = 4,
  parameter logic [7:0] MASK_ID    = 8'h82,
  parameter logic [7:0] ACK_ID     = 8'h83,
  parameter logic [7:0] STATUS_ID  = 8'h22,
  parameter logic [7:0] PEND_ID    = 8'h23,
  parameter int         INT_PULSE  = 2,
  parameter int         GAP_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SRC-1:0] src_in_i,
  input  logic [7:0]       port_id_i,
  input  logic [7:0]       out_port_i,
  input  logic             io_strb_i,
  output logic [7:0]       rd_data_o,
  output logic             rd_hit_o,
  output logic             interrupt_o
);

  // One down-counter serves both the pulse width and the post-ACK gap.
  localparam int CNT_MAX = (INT_PULSE > GAP_CYCLES) ? INT_PULSE : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] C_PULSE_LD = CNT_W'(INT_PULSE - 1);
  localparam logic [CNT_W-1:0] C_GAP_LD   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSERT   = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  state_t           state_q;
  logic [2:0]       active_id_q;
  logic [CNT_W-1:0] cnt_q;
  logic             interrupt_q;
  logic [N_SRC-1:0] src_d_q;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] pend_d;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] req;
  logic [2:0]       enc_id;
  logic             mask_wr;
  logic             ack_wr;

  // Bus decode, priority encode (lowest index wins) and pending next-state.
  always_comb begin
    mask_wr = io_strb_i && (port_id_i == MASK_ID);
    ack_wr  = io_strb_i && (port_id_i == ACK_ID) &&
              ((state_q == S_ASSERT) || (state_q == S_WAIT_ACK));
    req     = pend_q & mask_q;
    enc_id  = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) enc_id = 3'(i);
    end
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = ack_wr && (active_id_q == 3'(i));
    end
    // A fresh edge overrides a same-cycle clear so that edge is not lost.
    pend_d = (pend_q & ~clr) | (src_in_i & ~src_d_q);
  end

  // Edge capture, pending latch and enable mask register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_d_q <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
    end else begin
      src_d_q <= src_in_i;
      pend_q  <= pend_d;
      if (mask_wr) mask_q <= out_port_i[N_SRC-1:0];
    end
  end

  // Dispatch FSM: pulse INTERRUPT, wait for ACK, then hold off for the gap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      active_id_q <= 3'd0;
      cnt_q       <= '0;
      interrupt_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            active_id_q <= enc_id;
            cnt_q       <= C_PULSE_LD;
            interrupt_q <= 1'b1;
            state_q     <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          if (ack_wr) begin
            interrupt_q <= 1'b0;
            cnt_q       <= C_GAP_LD;
            state_q     <= S_GAP;
          end else if (cnt_q == '0) begin
            interrupt_q <= 1'b0;
            state_q     <= S_WAIT_ACK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_WAIT_ACK: begin
          if (ack_wr) begin
            interrupt_q <= 1'b0;
            cnt_q       <= C_GAP_LD;
            state_q     <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) state_q <= S_IDLE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: begin
          interrupt_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // Combinational read port for the status and pending registers.
  always_comb begin
    rd_hit_o  = (port_id_i == STATUS_ID) || (port_id_i == PEND_ID);
    rd_data_o = 8'h00;
    if (port_id_i == STATUS_ID) begin
      rd_data_o = {(state_q != S_IDLE), 4'b0000, active_id_q};
    end else if (port_id_i == PEND_ID) begin
      rd_data_o[N_SRC-1:0] = pend_q;
    end
  end

  assign interrupt_o = interrupt_q;

endmodule
`default_nettype wire

// File: tb/tb_rat_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rat_int_ctrl
// Description : Directed self-checking bench for rat_int_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rat_int_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [3:0] src_in_i;
  logic [7:0] port_id_i;
  logic [7:0] out_port_i;
  logic       io_strb_i;
  logic [7:0] rd_data_o;
  logic       rd_hit_o;
  logic       interrupt_o;

  int errors = 0;
  int checks = 0;

  rat_int_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .src_in_i    (src_in_i),
    .port_id_i   (port_id_i),
    .out_port_i  (out_port_i),
    .io_strb_i   (io_strb_i),
    .rd_data_o   (rd_data_o),
    .rd_hit_o    (rd_hit_o),
    .interrupt_o (interrupt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input logic exp);
    chk(tag, {7'd0, interrupt_o}, {7'd0, exp});
  endtask

  task automatic rd(input string tag, input logic [7:0] id, input logic [7:0] exp);
    port_id_i = id;
    #1;
    chk(tag, rd_data_o, exp);
    port_id_i = 8'h00;
  endtask

  // Single-cycle bus write; takes effect at the next rising edge.
  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    port_id_i  = id;
    out_port_i = data;
    io_strb_i  = 1'b1;
    tick();
    io_strb_i  = 1'b0;
    port_id_i  = 8'h00;
    out_port_i = 8'h00;
  endtask

  initial begin
    rst_ni     = 1'b0;
    src_in_i   = 4'h0;
    port_id_i  = 8'h00;
    out_port_i = 8'h00;
    io_strb_i  = 1'b0;

    // ---- reset state ----
    #2;
    chk_int("rst_int", 1'b0);
    rd("rst_status", 8'h22, 8'h00);
    rd("rst_pend", 8'h23, 8'h00);
    port_id_i = 8'h22; #1;
    chk("rst_rdhit_status", {7'd0, rd_hit_o}, 8'h01);
    port_id_i = 8'h82; #1;
    chk("rd_nohit", {7'd0, rd_hit_o}, 8'h00);
    chk("rd_nohit_data", rd_data_o, 8'h00);
    port_id_i = 8'h00;
    tick(); tick();
    rst_ni = 1'b1;
    tick();

    // ---- test 1: single source dispatch ----
    wr(8'h82, 8'h0F);
    src_in_i = 4'b0100;
    tick();                       // edge k: pend[2] latched
    src_in_i = 4'b0000;
    chk_int("t1_int_k", 1'b0);
    rd("t1_pend_k", 8'h23, 8'h04);
    tick();                       // k+1
    chk_int("t1_int_k1", 1'b1);
    tick();                       // k+2
    chk_int("t1_int_k2", 1'b1);
    rd("t1_status", 8'h22, 8'h82);
    rd("t1_pend", 8'h23, 8'h04);
    tick();                       // k+3
    chk_int("t1_int_k3", 1'b0);
    tick(); tick();
    chk_int("t1_int_wait", 1'b0);
    rd("t1_status_wait", 8'h22, 8'h82);

    // ---- test 2: ACK in WAIT_ACK, gap, return to idle ----
    wr(8'h83, 8'h00);             // edge a
    rd("t2_pend_ack", 8'h23, 8'h00);
    rd("t2_status_gap", 8'h22, 8'h82);
    tick(); tick(); tick();       // a+3
    rd("t2_status_a3", 8'h22, 8'h82);
    tick();                       // a+4
    rd("t2_status_idle", 8'h22, 8'h02);
    tick(); tick();
    chk_int("t2_no_int", 1'b0);

    // ---- test 3: simultaneous edges, priority ----
    src_in_i = 4'b1010;
    tick();
    src_in_i = 4'b0000;
    rd("t3_pend_both", 8'h23, 8'h0A);
    tick();
    chk_int("t3_int_id1", 1'b1);
    rd("t3_status_id1", 8'h22, 8'h81);
    tick(); tick();
    chk_int("t3_int_low", 1'b0);
    wr(8'h83, 8'h00);             // edge a
    rd("t3_pend_after1", 8'h23, 8'h08);
    tick(); tick(); tick(); tick(); // a+4
    chk_int("t3_gap_hold", 1'b0);
    tick();                       // a+5
    chk_int("t3_int_id3", 1'b1);
    rd("t3_status_id3", 8'h22, 8'h83);
    tick(); tick();
    chk_int("t3_int_low3", 1'b0);
    wr(8'h83, 8'h00);
    rd("t3_pend_clear", 8'h23, 8'h00);
    tick(); tick(); tick(); tick();
    rd("t3_status_idle", 8'h22, 8'h03);

    // ---- write to an unrelated port has no effect ----
    wr(8'h84, 8'hFF);
    rd("other_port_status", 8'h22, 8'h03);

    // ---- test 4: masked source, then enable ----
    wr(8'h82, 8'h00);
    src_in_i = 4'b0001;
    tick();
    src_in_i = 4'b0000;
    tick(); tick();
    chk_int("t4_masked_int", 1'b0);
    rd("t4_masked_pend", 8'h23, 8'h01);
    rd("t4_masked_status", 8'h22, 8'h03);
    wr(8'h82, 8'h01);             // edge m
    chk_int("t4_int_m", 1'b0);
    tick();                       // m+1
    chk_int("t4_int_m1", 1'b1);
    rd("t4_status", 8'h22, 8'h80);
    tick(); tick();
    chk_int("t4_int_low", 1'b0);

    // ---- test 5: new edge on the active source during its ACK ----
    port_id_i = 8'h83;
    io_strb_i = 1'b1;
    src_in_i  = 4'b0001;
    tick();                       // edge a
    io_strb_i = 1'b0;
    port_id_i = 8'h00;
    src_in_i  = 4'b0000;
    rd("t5_pend_kept", 8'h23, 8'h01);
    rd("t5_status_gap", 8'h22, 8'h80);
    tick(); tick(); tick(); tick(); // a+4
    chk_int("t5_gap_hold", 1'b0);
    tick();                       // a+5
    chk_int("t5_redispatch", 1'b1);
    rd("t5_status", 8'h22, 8'h80);

    // ---- test 6: asynchronous reset during ASSERT ----
    rst_ni = 1'b0;
    #1;
    chk_int("t6_int_rst", 1'b0);
    rd("t6_pend_rst", 8'h23, 8'h00);
    rd("t6_status_rst", 8'h22, 8'h00);
    #1;
    rst_ni = 1'b1;
    src_in_i = 4'b0010;
    tick();
    src_in_i = 4'b0000;
    tick(); tick();
    chk_int("t6_mask_cleared_int", 1'b0);
    rd("t6_pend_latched", 8'h23, 8'h02);
    rd("t6_status_idle", 8'h22, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound on total run time in case the sequence stalls.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
